// File: rtl/booth_mul_pkg.sv
// ============================================================================
// Module      : booth_mul_pkg
// Description : Shared types and Booth recoding constants for booth_mul.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_mul_pkg;

    // {Q[0], q_1} pairs that require an accumulator update; the others hold.
    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage : booth_mul_pkg

`default_nettype wire

// File: rtl/booth_mul_if.sv
// ============================================================================
// Module      : booth_mul_if
// Description : Start/done handshake and operand/product bus of booth_mul.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface booth_mul_if #(
    parameter int WIDTH = 8
);
    logic                      start;
    logic signed [WIDTH-1:0]   a;
    logic signed [WIDTH-1:0]   b;
    logic signed [2*WIDTH-1:0] c;
    logic                      busy;
    logic                      done;

    modport master (
        output start, a, b,
        input  c, busy, done
    );

    modport slave (
        input  start, a, b,
        output c, busy, done
    );
endinterface : booth_mul_if

`default_nettype wire

// File: rtl/booth_mul_step.sv
// ============================================================================
// Module      : booth_mul_step
// Description : One radix-2 Booth iteration: add/sub M, then arithmetic shift
//               of {A, Q, q_1} right by one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mul_step
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc_i;
        unique case ({q_i[0], q1_i})
            PAIR_ADD: sum = acc_i + m_i;
            PAIR_SUB: sum = acc_i - m_i;
            default:  sum = acc_i;
        endcase
    end

    // Guard bit in the accumulator is the sign replicated by the shift.
    assign acc_o = {sum[WIDTH], sum[WIDTH:1]};
    assign q_o   = {sum[0], q_i[WIDTH-1:1]};
    assign q1_o  = q_i[0];

endmodule : booth_mul_step

`default_nettype wire

// File: rtl/booth_mul.sv
// ============================================================================
// Module      : booth_mul
// Description : Sequential signed WIDTHxWIDTH radix-2 Booth multiplier with a
//               single-pulse start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mul
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    booth_mul_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e                 state_q, state_d;
    logic [WIDTH:0]         acc_q, acc_d;
    logic [WIDTH:0]         m_q, m_d;
    logic [WIDTH-1:0]       q_q, q_d;
    logic                   q1_q, q1_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     c_q, c_d;
    logic                   done_q, done_d;

    logic [WIDTH:0]         acc_s;
    logic [WIDTH-1:0]       q_s;
    logic                   q1_s;

    booth_mul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .q1_i  (q1_q),
        .m_i   (m_q),
        .acc_o (acc_s),
        .q_o   (q_s),
        .q1_o  (q1_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    q_d     = bus.b;
                    q1_d    = 1'b0;
                    m_d     = {bus.a[WIDTH-1], bus.a};
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_s;
                q_d   = q_s;
                q1_d  = q1_s;
                // Product is taken from the post-shift value of the last step.
                if (cnt_q == CNT_LAST) begin
                    c_d     = {acc_s[WIDTH-1:0], q_s};
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.c    = c_q;
    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = done_q;

endmodule : booth_mul

`default_nettype wire

// File: tb/tb_booth_mul.sv
// ============================================================================
// Module      : tb_booth_mul
// Description : Self-checking bench for booth_mul against integer a*b.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_mul;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    booth_mul_if #(.WIDTH(8)) bus ();

    booth_mul #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic signed [7:0] x, input logic signed [7:0] y);
        int p;
        p = int'(x) * int'(y);
        return p[15:0];
    endfunction

    // Starts one multiply from an idle, post-edge point; scrambles a/b after
    // acceptance and returns edges-to-done and the product seen with done.
    task automatic run_one(input logic [7:0] x, input logic [7:0] y,
                           output int lat, output logic [15:0] res);
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        lat = 0;
        res = 'x;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) break;
        end
        res = bus.c;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        #12;
        n_checks++;
        if (bus.c !== 16'h0000) $display("FAIL reset_c: got %h expected 0000", bus.c);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy);
        else n_pass++;
        n_checks++;
        if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int da[11]   = '{-16, -107, -86,   8, 7, 1,  60,  17,  -128,   -128,   127};
        int db[11]   = '{-16,   32,  35, -65, 0, 1,   5,  28,  -128,    127,   127};
        int dexp[11] = '{256, -3424, -3010, -520, 0, 1, 300, 476, 16384, -16256, 16129};
        int lat;
        logic [15:0] res;
        for (int i = 0; i < 11; i++) begin
            run_one(8'(da[i]), 8'(db[i]), lat, res);
            n_checks++;
            if (res !== 16'(dexp[i]))
                $display("FAIL directed_%0d: got %0d expected %0d", i, $signed(res), dexp[i]);
            else n_pass++;
            n_checks++;
            if (lat !== 8) $display("FAIL directed_lat_%0d: got %0d expected 8", i, lat);
            else n_pass++;
        end
    endtask

    task automatic test_done_pulse();
        int lat;
        logic [15:0] res;
        run_one(8'(-5), 8'(9), lat, res);
        @(posedge clk); #1;
        n_checks++;
        if (bus.done !== 1'b0) $display("FAIL done_single_pulse: got %b expected 0", bus.done);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.c !== ref_mul(8'(-5), 8'(9)))
            $display("FAIL c_hold: got %0d expected -45", $signed(bus.c));
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [15:0] res;
        run_one(8'(100), 8'(-3), lat, res);
        bus.a     = 8'(55);
        bus.b     = 8'(-77);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.c !== 16'h0000) $display("FAIL midrst_c: got %h expected 0000", bus.c);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", bus.busy);
        else n_pass++;
        n_checks++;
        if (bus.done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", bus.done);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_one(8'(-33), 8'(21), lat, res);
        n_checks++;
        if (res !== ref_mul(8'(-33), 8'(21)))
            $display("FAIL after_rst: got %0d expected -693", $signed(res));
        else n_pass++;
        n_checks++;
        if (lat !== 8) $display("FAIL after_rst_lat: got %0d expected 8", lat);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        int lat;
        int extra_done;
        bus.a     = 8'(-77);
        bus.b     = 8'(13);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) break;
            if (lat == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'(99);
                bus.b     = 8'(-99);
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (bus.c !== ref_mul(8'(-77), 8'(13)))
            $display("FAIL ignore_start_c: got %0d expected -1001", $signed(bus.c));
        else n_pass++;
        n_checks++;
        if (lat !== 8) $display("FAIL ignore_start_lat: got %0d expected 8", lat);
        else n_pass++;
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) extra_done++;
        end
        n_checks++;
        if (extra_done !== 0) $display("FAIL ignore_start_queued: got %0d active cycles expected 0", extra_done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] xs[3];
        logic [7:0] ys[3];
        int idx  = 0;
        int last = 0;
        for (int i = 0; i < 3; i++) begin
            xs[i] = 8'($urandom);
            ys[i] = 8'($urandom);
        end
        bus.a     = xs[0];
        bus.b     = ys[0];
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                n_checks++;
                if (bus.c !== ref_mul(xs[idx], ys[idx]))
                    $display("FAIL b2b_c_%0d: got %0d expected %0d", idx, $signed(bus.c),
                             $signed(ref_mul(xs[idx], ys[idx])));
                else n_pass++;
                n_checks++;
                if ((cyc - last) !== ((idx == 0) ? 8 : 9))
                    $display("FAIL b2b_gap_%0d: got %0d expected %0d", idx, cyc - last,
                             (idx == 0) ? 8 : 9);
                else n_pass++;
                last = cyc;
                idx++;
                if (idx == 3) begin
                    bus.start = 1'b0;
                    break;
                end
                bus.a = xs[idx];
                bus.b = ys[idx];
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (idx !== 3) $display("FAIL b2b_count: got %0d expected 3", idx);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] res;
        logic [7:0]  x, y;
        for (int i = 0; i < 5000; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            run_one(x, y, lat, res);
            n_checks++;
            if (res !== ref_mul(x, y))
                $display("FAIL random_%0d: a=%0d b=%0d got %0d expected %0d", i, $signed(x),
                         $signed(y), $signed(res), $signed(ref_mul(x, y)));
            else n_pass++;
            n_checks++;
            if (lat !== 8) $display("FAIL random_lat_%0d: got %0d expected 8", i, lat);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_done_pulse();
        test_reset_mid();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_booth_mul

`default_nettype wire
